// File: rtl/jam_perm_sched.sv
// Lexicographic permutation scheduler for the JAM cost datapath.
// Walks all N! job assignments from the identity through an iterative next-permutation FSM.
module jam_perm_sched #(
  parameter int N    = 8,
  parameter int IDXW = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_perm_valid,
  input  logic              i_perm_ready,
  output logic [3*N-1:0]    o_perm,
  output logic              o_perm_last,
  output logic [IDXW-1:0]   o_perm_index,
  output logic              o_done
);

  localparam int IW = (N > 2) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_POS  = IW'(N - 1);
  localparam logic [IW-1:0] PIV_START = IW'(N - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EMIT,
    S_FIND_PIVOT,
    S_FIND_SUCC,
    S_SWAP,
    S_REVERSE,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [N-1:0][2:0]   r_p;
  logic [IW-1:0]       r_i;
  logic [IW-1:0]       r_j;
  logic [IW-1:0]       r_lo;
  logic [IW-1:0]       r_hi;
  logic                r_busy;
  logic                r_valid;
  logic                r_done;
  logic [IDXW-1:0]     r_index;

  logic [N-1:0][2:0]   w_ident;
  logic                w_desc;
  logic                w_hs;

  // The descending arrangement is the only permutation with no successor.
  always_comb begin
    w_desc = 1'b1;
    for (int k = 0; k < N; k++) begin
      w_ident[k] = 3'(k);
      if (r_p[k] != 3'(N - 1 - k)) w_desc = 1'b0;
    end
  end

  assign w_hs = r_valid & i_perm_ready;

  // r_i doubles as the latched pivot once FIND_PIVOT succeeds.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_p     <= w_ident;
      r_i     <= '0;
      r_j     <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_index <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_p     <= w_ident;
            r_index <= '0;
            r_busy  <= 1'b1;
            r_valid <= 1'b1;
            r_state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (w_hs) begin
            r_valid <= 1'b0;
            if (w_desc) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_i     <= PIV_START;
              r_state <= S_FIND_PIVOT;
            end
          end
        end
        S_FIND_PIVOT: begin
          if (r_p[r_i] < r_p[r_i + IW'(1)]) begin
            r_j     <= LAST_POS;
            r_state <= S_FIND_SUCC;
          end else begin
            r_i <= r_i - IW'(1);
          end
        end
        S_FIND_SUCC: begin
          if (r_p[r_j] > r_p[r_i]) r_state <= S_SWAP;
          else                     r_j     <= r_j - IW'(1);
        end
        S_SWAP: begin
          r_p[r_i] <= r_p[r_j];
          r_p[r_j] <= r_p[r_i];
          r_lo     <= r_i + IW'(1);
          r_hi     <= LAST_POS;
          r_state  <= S_REVERSE;
        end
        S_REVERSE: begin
          if (r_lo < r_hi) begin
            r_p[r_lo] <= r_p[r_hi];
            r_p[r_hi] <= r_p[r_lo];
            r_lo      <= r_lo + IW'(1);
            r_hi      <= r_hi - IW'(1);
          end else begin
            r_index <= r_index + IDXW'(1);
            r_valid <= 1'b1;
            r_state <= S_EMIT;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_perm_valid = r_valid;
  assign o_perm       = r_p;
  assign o_perm_last  = r_valid & w_desc;
  assign o_perm_index = r_index;
  assign o_done       = r_done;

endmodule

// File: tb/tb_jam_perm_sched.sv
// Directed bench for jam_perm_sched: N=8, N=3 and N=2 instances exercised in turn.
module tb_jam_perm_sched;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;

  logic rst8, start8, ready8, busy8, valid8, last8, done8;
  logic [23:0] perm8;
  logic [15:0] idx8;
  logic rst3, start3, ready3, busy3, valid3, last3, done3;
  logic [8:0]  perm3;
  logic [15:0] idx3;
  logic rst2, start2, ready2, busy2, valid2, last2, done2;
  logic [5:0]  perm2;
  logic [15:0] idx2;

  jam_perm_sched #(.N(8), .IDXW(16)) u_dut8 (
    .CLK(CLK), .RST(rst8), .i_start(start8), .o_busy(busy8), .o_perm_valid(valid8),
    .i_perm_ready(ready8), .o_perm(perm8), .o_perm_last(last8), .o_perm_index(idx8), .o_done(done8));
  jam_perm_sched #(.N(3), .IDXW(16)) u_dut3 (
    .CLK(CLK), .RST(rst3), .i_start(start3), .o_busy(busy3), .o_perm_valid(valid3),
    .i_perm_ready(ready3), .o_perm(perm3), .o_perm_last(last3), .o_perm_index(idx3), .o_done(done3));
  jam_perm_sched #(.N(2), .IDXW(16)) u_dut2 (
    .CLK(CLK), .RST(rst2), .i_start(start2), .o_busy(busy2), .o_perm_valid(valid2),
    .i_perm_ready(ready2), .o_perm(perm2), .o_perm_last(last2), .o_perm_index(idx2), .o_done(done2));

  // Digit strings read worker0 first, one hex nibble per worker.
  function automatic logic [23:0] pk8(input logic [31:0] d);
    logic [23:0] r;
    for (int k = 0; k < 8; k++) r[3*k +: 3] = d[4*(7-k) +: 3];
    return r;
  endfunction
  function automatic logic [8:0] pk3(input logic [11:0] d);
    logic [8:0] r;
    for (int k = 0; k < 3; k++) r[3*k +: 3] = d[4*(2-k) +: 3];
    return r;
  endfunction
  function automatic logic [5:0] pk2(input logic [7:0] d);
    logic [5:0] r;
    for (int k = 0; k < 2; k++) r[3*k +: 3] = d[4*(1-k) +: 3];
    return r;
  endfunction
  function automatic logic [23:0] key8(input logic [23:0] p);
    logic [23:0] r;
    for (int k = 0; k < 8; k++) r[3*(7-k) +: 3] = p[3*k +: 3];
    return r;
  endfunction
  function automatic logic [7:0] mask8(input logic [23:0] p);
    logic [7:0] m;
    m = '0;
    for (int k = 0; k < 8; k++) m[p[3*k +: 3]] = 1'b1;
    return m;
  endfunction

  task automatic test_reset();
    rst8 = 1; rst3 = 1; rst2 = 1;
    start8 = 0; start3 = 0; start2 = 0;
    ready8 = 0; ready3 = 0; ready2 = 0;
    repeat (2) @(negedge CLK);
    n_total++; if (busy8 !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy8); else n_pass++;
    n_total++; if (valid8 !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", valid8); else n_pass++;
    n_total++; if (done8 !== 1'b0) $display("FAIL reset_done got=%0b exp=0", done8); else n_pass++;
    n_total++; if (last8 !== 1'b0) $display("FAIL reset_last got=%0b exp=0", last8); else n_pass++;
    n_total++; if (idx8 !== 16'd0) $display("FAIL reset_index got=%0d exp=0", idx8); else n_pass++;
    n_total++; if (perm8 !== pk8(32'h01234567)) $display("FAIL reset_perm8 got=%h exp=%h", perm8, pk8(32'h01234567)); else n_pass++;
    n_total++; if (perm3 !== pk3(12'h012)) $display("FAIL reset_perm3 got=%h exp=%h", perm3, pk3(12'h012)); else n_pass++;
    rst8 = 0; rst3 = 0; rst2 = 0;
    @(negedge CLK);
  endtask

  task automatic test_n3_sequence();
    logic [11:0] exp3 [6];
    int cnt;
    exp3 = '{12'h012, 12'h021, 12'h102, 12'h120, 12'h201, 12'h210};
    ready3 = 1;
    start3 = 1;
    @(negedge CLK);
    start3 = 0;
    n_total++; if (busy3 !== 1'b1 || valid3 !== 1'b1) $display("FAIL n3_start_latency busy=%0b valid=%0b exp=1/1", busy3, valid3); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      cnt = 0;
      while (valid3 !== 1'b1 && cnt < 20) begin @(negedge CLK); cnt++; end
      n_total++; if (valid3 !== 1'b1) $display("FAIL n3_wait_valid k=%0d timed out", k); else n_pass++;
      n_total++; if (perm3 !== pk3(exp3[k])) $display("FAIL n3_perm k=%0d got=%h exp=%h", k, perm3, pk3(exp3[k])); else n_pass++;
      n_total++; if (idx3 !== 16'(k)) $display("FAIL n3_index got=%0d exp=%0d", idx3, k); else n_pass++;
      n_total++; if (last3 !== (k == 5)) $display("FAIL n3_last k=%0d got=%0b", k, last3); else n_pass++;
      n_total++; if (done3 !== 1'b0) $display("FAIL n3_early_done k=%0d got=%0b exp=0", k, done3); else n_pass++;
      @(negedge CLK);
    end
    n_total++; if (done3 !== 1'b1 || busy3 !== 1'b1) $display("FAIL n3_done_pulse done=%0b busy=%0b exp=1/1", done3, busy3); else n_pass++;
    @(negedge CLK);
    n_total++; if (done3 !== 1'b0 || busy3 !== 1'b0) $display("FAIL n3_done_end done=%0b busy=%0b exp=0/0", done3, busy3); else n_pass++;
    ready3 = 0;
  endtask

  task automatic test_n8_gap();
    int cnt;
    ready8 = 0;
    start8 = 1;
    @(negedge CLK);
    start8 = 0;
    n_total++; if (valid8 !== 1'b1 || busy8 !== 1'b1) $display("FAIL n8_start valid=%0b busy=%0b exp=1/1", valid8, busy8); else n_pass++;
    n_total++; if (idx8 !== 16'd0) $display("FAIL n8_first_index got=%0d exp=0", idx8); else n_pass++;
    repeat (3) @(negedge CLK);
    n_total++; if (valid8 !== 1'b1 || perm8 !== pk8(32'h01234567)) $display("FAIL n8_stall_ident valid=%0b perm=%h", valid8, perm8); else n_pass++;
    n_total++; if (last8 !== 1'b0) $display("FAIL n8_ident_last got=%0b exp=0", last8); else n_pass++;
    ready8 = 1;
    @(negedge CLK);
    ready8 = 0;
    cnt = 0;
    while (valid8 !== 1'b1 && cnt < 40) begin @(negedge CLK); cnt++; end
    n_total++; if (cnt != 4) $display("FAIL n8_gap got=%0d exp=4", cnt); else n_pass++;
    n_total++; if (perm8 !== pk8(32'h01234576)) $display("FAIL n8_second_perm got=%h exp=%h", perm8, pk8(32'h01234576)); else n_pass++;
    n_total++; if (idx8 !== 16'd1) $display("FAIL n8_second_index got=%0d exp=1", idx8); else n_pass++;
  endtask

  logic hs99;

  task automatic test_backpressure();
    logic [31:0] exp8 [7];
    logic        prev_v, prev_r;
    logic [23:0] prev_p, seen_key;
    logic [15:0] prev_i, seen_i;
    int cycles;
    exp8 = '{32'h01234567, 32'h01234576, 32'h01234657, 32'h01234675,
             32'h01234756, 32'h01234765, 32'h01235467};
    hs99 = 0;
    cycles = 0;
    seen_i = idx8;
    seen_key = key8(perm8);
    ready8 = 1'($urandom_range(0, 1));
    prev_v = valid8; prev_p = perm8; prev_i = idx8; prev_r = ready8;
    while (!hs99 && cycles < 20000) begin
      @(negedge CLK);
      cycles++;
      if (prev_v && !prev_r) begin
        n_total++;
        if (valid8 !== 1'b1 || perm8 !== prev_p || idx8 !== prev_i)
          $display("FAIL bp_stall valid=%0b perm=%h idx=%0d exp perm=%h idx=%0d", valid8, perm8, idx8, prev_p, prev_i);
        else n_pass++;
      end
      if (valid8 === 1'b1 && idx8 !== seen_i) begin
        n_total++; if (idx8 !== seen_i + 16'd1) $display("FAIL bp_index got=%0d exp=%0d", idx8, seen_i + 16'd1); else n_pass++;
        n_total++; if (!(key8(perm8) > seen_key)) $display("FAIL bp_lex_order got=%h prev=%h", key8(perm8), seen_key); else n_pass++;
        n_total++; if (mask8(perm8) !== 8'hFF) $display("FAIL bp_not_perm got=%h", perm8); else n_pass++;
        if (idx8 <= 16'd6) begin
          n_total++; if (perm8 !== pk8(exp8[idx8])) $display("FAIL bp_table idx=%0d got=%h exp=%h", idx8, perm8, pk8(exp8[idx8])); else n_pass++;
        end
        seen_i = idx8;
        seen_key = key8(perm8);
      end
      ready8 = 1'($urandom_range(0, 1));
      if (valid8 === 1'b1 && ready8 && idx8 == 16'd99) begin
        n_total++; if (perm8 !== pk8(32'h01273564)) $display("FAIL bp_perm99 got=%h exp=%h", perm8, pk8(32'h01273564)); else n_pass++;
        hs99 = 1;
      end
      prev_v = valid8; prev_p = perm8; prev_i = idx8; prev_r = ready8;
    end
    n_total++; if (!hs99) $display("FAIL bp_reach_99 timed out after %0d cycles", cycles); else n_pass++;
  endtask

  // 01273564 -> 01273645: two pivot, two successor, one swap cycle, so the 6th cycle is REVERSE.
  task automatic test_reset_mid();
    int cnt;
    repeat (6) @(negedge CLK);
    ready8 = 0;
    n_total++; if (valid8 !== 1'b0 || busy8 !== 1'b1) $display("FAIL mid_in_gap valid=%0b busy=%0b exp=0/1", valid8, busy8); else n_pass++;
    rst8 = 1;
    @(negedge CLK);
    n_total++; if (busy8 !== 1'b0 || valid8 !== 1'b0) $display("FAIL mid_abort busy=%0b valid=%0b exp=0/0", busy8, valid8); else n_pass++;
    n_total++; if (perm8 !== pk8(32'h01234567)) $display("FAIL mid_abort_perm got=%h exp=%h", perm8, pk8(32'h01234567)); else n_pass++;
    n_total++; if (done8 !== 1'b0) $display("FAIL mid_abort_done got=%0b exp=0", done8); else n_pass++;
    start8 = 1;
    @(negedge CLK);
    rst8 = 0;
    start8 = 0;
    @(negedge CLK);
    n_total++; if (busy8 !== 1'b0 || valid8 !== 1'b0 || done8 !== 1'b0) $display("FAIL start_with_rst busy=%0b valid=%0b done=%0b exp=0/0/0", busy8, valid8, done8); else n_pass++;
    start8 = 1;
    @(negedge CLK);
    start8 = 0;
    n_total++; if (valid8 !== 1'b1 || idx8 !== 16'd0 || perm8 !== pk8(32'h01234567)) $display("FAIL restart valid=%0b idx=%0d perm=%h", valid8, idx8, perm8); else n_pass++;
  endtask

  task automatic test_start_ignored();
    int cnt;
    ready8 = 1;
    cnt = 0;
    while (!(valid8 === 1'b1 && idx8 == 16'd3) && cnt < 200) begin @(negedge CLK); cnt++; end
    n_total++; if (!(valid8 === 1'b1 && idx8 == 16'd3)) $display("FAIL ign_reach_3 timed out"); else n_pass++;
    @(negedge CLK);
    start8 = 1;
    @(negedge CLK);
    start8 = 0;
    cnt = 0;
    while (valid8 !== 1'b1 && cnt < 40) begin @(negedge CLK); cnt++; end
    n_total++; if (idx8 !== 16'd4 || perm8 !== pk8(32'h01234756)) $display("FAIL ign_continue idx=%0d perm=%h exp idx=4 perm=%h", idx8, perm8, pk8(32'h01234756)); else n_pass++;
    n_total++; if (busy8 !== 1'b1) $display("FAIL ign_busy got=%0b exp=1", busy8); else n_pass++;
    ready8 = 0;
  endtask

  task automatic test_n2();
    int cnt;
    ready2 = 1;
    start2 = 1;
    @(negedge CLK);
    start2 = 0;
    n_total++; if (valid2 !== 1'b1 || perm2 !== pk2(8'h01) || last2 !== 1'b0) $display("FAIL n2_first valid=%0b perm=%h last=%0b", valid2, perm2, last2); else n_pass++;
    @(negedge CLK);
    cnt = 0;
    while (valid2 !== 1'b1 && cnt < 20) begin @(negedge CLK); cnt++; end
    n_total++; if (cnt != 4) $display("FAIL n2_gap got=%0d exp=4", cnt); else n_pass++;
    n_total++; if (perm2 !== pk2(8'h10) || idx2 !== 16'd1 || last2 !== 1'b1) $display("FAIL n2_second perm=%h idx=%0d last=%0b", perm2, idx2, last2); else n_pass++;
    @(negedge CLK);
    n_total++; if (done2 !== 1'b1 || busy2 !== 1'b1) $display("FAIL n2_done done=%0b busy=%0b exp=1/1", done2, busy2); else n_pass++;
    @(negedge CLK);
    n_total++; if (done2 !== 1'b0 || busy2 !== 1'b0 || valid2 !== 1'b0) $display("FAIL n2_idle done=%0b busy=%0b valid=%0b", done2, busy2, valid2); else n_pass++;
    ready2 = 0;
  endtask

  initial begin
    test_reset();
    test_n3_sequence();
    test_n8_gap();
    test_backpressure();
    test_reset_mid();
    test_start_ignored();
    test_n2();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
